// File: rtl/delay_ctrl.sv
// delay_ctrl: control-plane sequencer for the delay effect.
// Host writes land in shadow registers; a commit applies all shadows together
// on the next sample strobe (smp_valid). Feedback is clamped to FDB_MAX.
// Optional macro DELAY_CTRL_RAMP_EN: when defined, delay glides toward its
// target by at most DLY_STEP per sample; when undefined, delay jumps directly.
module delay_ctrl #(
  parameter int unsigned BLEND_B  = 4,
  parameter int unsigned DLY_B    = 14,
  parameter int unsigned FDB_B    = 10,
  parameter int unsigned CFG_W    = 16,
  parameter int unsigned DLY_STEP = 4,
  parameter int unsigned DLY_RST  = 1024,
  parameter int unsigned FDB_MAX  = 896
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_wr,
  input  logic [1:0]         cfg_addr,
  input  logic [CFG_W-1:0]   cfg_wdata,
  output logic               cfg_ready,
  input  logic               smp_valid,
  output logic [BLEND_B-1:0] blend,
  output logic [DLY_B-1:0]   delay,
  output logic [FDB_B-1:0]   feedbk,
  output logic               busy
);

  localparam logic [DLY_B-1:0] DLY_RST_V  = DLY_B'(DLY_RST);
  localparam logic [FDB_B-1:0] FDB_CLAMP  = FDB_B'(FDB_MAX);

  // Elaboration-time parameter sanity checks
  if (DLY_STEP < 1) begin : g_chk_step
    $error("delay_ctrl: DLY_STEP must be >= 1");
  end
  if (CFG_W < BLEND_B || CFG_W < DLY_B || CFG_W < FDB_B) begin : g_chk_cfgw
    $error("delay_ctrl: CFG_W narrower than a control field");
  end
  if (FDB_MAX >= (1 << FDB_B)) begin : g_chk_fdb
    $error("delay_ctrl: FDB_MAX does not fit in FDB_B bits");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_RAMP
  } state_t;

  state_t             state;
  logic [BLEND_B-1:0] blend_sh;
  logic [DLY_B-1:0]   dly_sh;
  logic [FDB_B-1:0]   fdb_sh;
  logic [DLY_B-1:0]   target;
  logic [DLY_B-1:0]   sel_tgt;
  logic [DLY_B-1:0]   step_val;
  logic [FDB_B-1:0]   fdb_in;
  logic [FDB_B-1:0]   fdb_clamped;
  logic               wr_acc;
  logic               commit_acc;
  logic               unused_wdata;

  assign wr_acc       = cfg_wr && cfg_ready;
  assign commit_acc   = wr_acc && (cfg_addr == 2'd3);
  assign fdb_in       = cfg_wdata[FDB_B-1:0];
  assign fdb_clamped  = (fdb_in > FDB_CLAMP) ? FDB_CLAMP : fdb_in;
  assign unused_wdata = ^cfg_wdata;

  // The applying strobe steps toward the freshly committed shadow, later strobes toward the held target
  assign sel_tgt = (state == ST_PEND) ? dly_sh : target;

`ifdef DELAY_CTRL_RAMP_EN
  localparam logic [DLY_B:0]   STEP_W = (DLY_B+1)'(DLY_STEP);
  localparam logic [DLY_B-1:0] STEP_D = DLY_B'(DLY_STEP);
  logic [DLY_B:0] diff;

  // One bounded ramp step; the add/sub only happens when the gap exceeds the step, so it cannot wrap
  always_comb begin
    diff     = '0;
    step_val = sel_tgt;
    if (sel_tgt >= delay) begin
      diff     = {1'b0, sel_tgt} - {1'b0, delay};
      step_val = (diff <= STEP_W) ? sel_tgt : delay + STEP_D;
    end else begin
      diff     = {1'b0, delay} - {1'b0, sel_tgt};
      step_val = (diff <= STEP_W) ? sel_tgt : delay - STEP_D;
    end
  end
`else
  assign step_val = sel_tgt;
`endif

  // Shadow registers, sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      blend_sh  <= '0;
      dly_sh    <= DLY_RST_V;
      fdb_sh    <= '0;
      target    <= DLY_RST_V;
      blend     <= '0;
      delay     <= DLY_RST_V;
      feedbk    <= '0;
      cfg_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (wr_acc) begin
        case (cfg_addr)
          2'd0:    blend_sh <= cfg_wdata[BLEND_B-1:0];
          2'd1:    dly_sh   <= cfg_wdata[DLY_B-1:0];
          2'd2:    fdb_sh   <= fdb_clamped;
          default: ;
        endcase
      end
      case (state)
        ST_IDLE: begin
          if (commit_acc) begin
            state     <= ST_PEND;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_PEND: begin
          if (smp_valid) begin
            blend     <= blend_sh;
            feedbk    <= fdb_sh;
            target    <= dly_sh;
            delay     <= step_val;
            cfg_ready <= 1'b1;
            if (step_val != dly_sh) begin
              state <= ST_RAMP;
              busy  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        ST_RAMP: begin
          if (smp_valid) begin
            delay <= step_val;
          end
          // A commit during the glide takes priority; the ramp resumes toward the new target
          if (commit_acc) begin
            state     <= ST_PEND;
            cfg_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (smp_valid && step_val == target) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cfg_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed testbench for delay_ctrl (default parameters).
module tb_delay_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_ready;
  logic        smp_valid;
  logic [3:0]  blend;
  logic [13:0] delay;
  logic [9:0]  feedbk;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned exp_dly;

  delay_ctrl #(
    .BLEND_B (4),
    .DLY_B   (14),
    .FDB_B   (10),
    .CFG_W   (16),
    .DLY_STEP(4),
    .DLY_RST (1024),
    .FDB_MAX (896)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready),
    .smp_valid(smp_valid),
    .blend    (blend),
    .delay    (delay),
    .feedbk   (feedbk),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wr    = 1'b0;
  endtask

  task automatic strobe();
    smp_valid = 1'b1;
    tick();
    smp_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; smp_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("rst_blend", 32'(blend), 0);
    check("rst_delay", 32'(delay), 1024);
    check("rst_feedbk", 32'(feedbk), 0);
    check("rst_ready", 32'(cfg_ready), 1);
    check("rst_busy", 32'(busy), 0);

    // Shadow writes: blend upper bits ignored, nothing visible before commit+strobe
    wr(2'd0, 16'hFFF9);
    wr(2'd2, 16'd500);
    check("shadow_not_live", 32'(blend), 0);
    wr(2'd3, 16'd0);
    check("commit_ready_low", 32'(cfg_ready), 0);
    check("commit_busy", 32'(busy), 1);
    wr(2'd0, 16'd3);            // dropped: not ready
    tick(); tick();
    check("pend_blend_hold", 32'(blend), 0);
    check("pend_fdb_hold", 32'(feedbk), 0);
    strobe();
    check("apply_blend", 32'(blend), 9);
    check("apply_fdb", 32'(feedbk), 500);
    check("apply_ready", 32'(cfg_ready), 1);
    check("apply_busy", 32'(busy), 0);
    strobe();
    check("idle_strobe_blend", 32'(blend), 9);

    // Feedback clamp; dropped blend write must not have reached the shadow
    wr(2'd2, 16'd1023);
    wr(2'd3, 16'd0);
    strobe();
    check("fdb_clamp", 32'(feedbk), 896);
    check("dropped_write", 32'(blend), 9);
    check("delay_unchanged", 32'(delay), 1024);

    // Small delay move
    wr(2'd1, 16'd1034);
    wr(2'd3, 16'd0);
    strobe();
`ifdef DELAY_CTRL_RAMP_EN
    check("ramp1", 32'(delay), 1028);
    check("ramp1_busy", 32'(busy), 1);
    tick(); tick();
    check("ramp_no_strobe", 32'(delay), 1028);
    strobe();
    check("ramp2", 32'(delay), 1032);
    strobe();
    check("ramp3", 32'(delay), 1034);
    check("ramp3_busy", 32'(busy), 0);
`else
    check("jump_1034", 32'(delay), 1034);
    check("jump_busy", 32'(busy), 0);
`endif

    // Commit coincident with smp_valid applies on the following strobe
    wr(2'd0, 16'd5);
    cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_wdata = '0; smp_valid = 1'b1;
    tick();
    cfg_wr = 1'b0; smp_valid = 1'b0;
    check("coinc_no_apply", 32'(blend), 9);
    check("coinc_pending", 32'(cfg_ready), 0);
    strobe();
    check("coinc_apply_next", 32'(blend), 5);
    check("coinc_fdb_kept", 32'(feedbk), 896);

    // Head toward 2000, then retarget to 1000 mid-ramp
    wr(2'd1, 16'd2000);
    wr(2'd3, 16'd0);
    strobe();
`ifdef DELAY_CTRL_RAMP_EN
    check("up1", 32'(delay), 1038);
    strobe();
    check("up2", 32'(delay), 1042);
`else
    check("jump_2000", 32'(delay), 2000);
    check("jump_2000_busy", 32'(busy), 0);
`endif
    wr(2'd1, 16'd1000);
    wr(2'd3, 16'd0);
    check("retarget_ready", 32'(cfg_ready), 0);
    check("retarget_busy", 32'(busy), 1);
    strobe();
`ifdef DELAY_CTRL_RAMP_EN
    check("reverse1", 32'(delay), 1038);
    exp_dly = 1038;
    for (int i = 0; i < 20 && busy; i++) begin
      strobe();
      exp_dly = (exp_dly - 1000 <= 4) ? 1000 : exp_dly - 4;
      check("reverse_step", 32'(delay), exp_dly);
    end
`endif
    check("settle_delay", 32'(delay), 1000);
    check("settle_busy", 32'(busy), 0);

    // Out-of-range delay write truncates to the field width
    wr(2'd1, 16'h7FFF);
    wr(2'd3, 16'd0);
    strobe();
`ifdef DELAY_CTRL_RAMP_EN
    check("wide_first_step", 32'(delay), 1004);
    check("wide_busy", 32'(busy), 1);
`else
    check("wide_trunc", 32'(delay), 16383);
    check("wide_busy", 32'(busy), 0);
`endif

    // Asynchronous reset with a commit pending (and mid-ramp when gliding)
    wr(2'd1, 16'd5);
    wr(2'd3, 16'd0);
    check("pre_reset_ready", 32'(cfg_ready), 0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_blend", 32'(blend), 0);
    check("arst_delay", 32'(delay), 1024);
    check("arst_feedbk", 32'(feedbk), 0);
    check("arst_ready", 32'(cfg_ready), 1);
    check("arst_busy", 32'(busy), 0);
    #2 reset_n = 1'b1;
    tick();
    strobe();
    check("post_rst_delay", 32'(delay), 1024);
    check("post_rst_busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
